// File: rtl/mc_boot_loader.sv
// rtl/mc_boot_loader.sv - framed byte-stream program loader for the multi-cycle computer memory
module mc_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  logic [2:0]  state;
  logic        armed;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [1:0]  byte_idx;
  logic [23:0] acc;
  logic [7:0]  csum;
  logic        fire;
  logic [16:0] new_len;
  logic [16:0] next_count;

  // armed keeps in_ready low for the first cycle out of reset
  assign in_ready   = armed && (state == S_LEN_HI || state == S_LEN_LO ||
                                state == S_DATA   || state == S_CHECK);
  assign fire       = in_valid && in_ready;
  assign new_len    = {1'b0, len_hi, in_data};
  assign next_count = 17'(words_loaded) + 17'd1;

  assign done     = (state == S_DONE);
  assign err      = (state == S_ERROR);
  assign cpu_rstn = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LEN_HI;
      armed        <= 1'b0;
      len_hi       <= '0;
      len          <= '0;
      byte_idx     <= '0;
      acc          <= '0;
      csum         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      armed  <= 1'b1;
      mem_we <= 1'b0;
      if (fire) begin
        case (state)
          S_LEN_HI: begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len      <= new_len[15:0];
            byte_idx <= '0;
            csum     <= '0;
            if (new_len == 17'd0 || new_len > MAX_WORDS) state <= S_ERROR;
            else                                         state <= S_DATA;
          end
          S_DATA: begin
            acc      <= {acc[15:0], in_data};
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // words_loaded doubles as the word index of the word being written
              mem_we       <= 1'b1;
              mem_addr     <= words_loaded[ADDR_W-1:0];
              mem_wdata    <= {acc, in_data};
              words_loaded <= words_loaded + 1'b1;
              if (next_count == {1'b0, len}) state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (in_data == csum) state <= S_DONE;
            else                 state <= S_ERROR;
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mc_boot_loader.sv
// tb/tb_mc_boot_loader.sv - scoreboard bench for mc_boot_loader with randomized frames
module tb_mc_boot_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rstn;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  mc_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rstn(cpu_rstn),
    .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cnt;
    int                cyc;
  } wr_t;

  wr_t         sb[$];
  wr_t         mon_e;
  logic [31:0] fw[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          accept_cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst) begin
      if (done && err) begin
        n_cmp++;
        n_fail++;
        $display("FAIL done_err_excl: got done=%0b err=%0b expected not both", done, err);
      end
      if (mem_we) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
        end else begin
          mon_e = sb.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
          chk("wr_data", 64'(mem_wdata), 64'(mon_e.data));
          chk("wr_count", 64'(words_loaded), 64'(mon_e.cnt));
          chk("wr_latency", 64'(cyc), 64'(mon_e.cyc));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_status", 64'({cpu_rstn, done, err}), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    sb.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_data = b;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no handshake expected byte %0h accepted", b);
    end
    accept_cyc = cyc;
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  // mode 0: random gaps; mode 1: valid toggling with a 5-cycle gap inside the second word
  function automatic int gap_for(input int mode, input int idx);
    if (mode == 1) return (idx == 5) ? 5 : 1;
    return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
  endfunction

  task automatic run_frame(input int n, input logic [7:0] sum_xor, input int mode);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] n16;
    int          idx;
    bit          n_ok;
    bit          ok;
    cs   = 8'h00;
    idx  = 0;
    n16  = 16'(n);
    n_ok = (n >= 1 && n <= (1 << ADDR_W));
    send_byte(n16[15:8], gap_for(mode, 0));
    send_byte(n16[7:0], gap_for(mode, 0));
    if (n_ok) begin
      for (int w = 0; w < n; w++) begin
        for (int k = 0; k < 4; k++) begin
          b = 8'(fw[w] >> (24 - 8 * k));
          cs = cs ^ b;
          send_byte(b, gap_for(mode, idx));
          idx++;
          if (k == 3) sb.push_back('{addr: ADDR_W'(w), data: fw[w], cnt: w + 1, cyc: accept_cyc});
        end
      end
      send_byte(cs ^ sum_xor, gap_for(mode, 0));
    end
    repeat (3) @(posedge clk);
    #1;
    ok = n_ok && (sum_xor == 8'h00);
    chk("pending_writes", 64'(sb.size()), 64'd0);
    chk("final_done", 64'(done), 64'(ok));
    chk("final_err", 64'(err), 64'(!ok));
    chk("final_cpu_rstn", 64'(cpu_rstn), 64'(ok));
    chk("final_in_ready", 64'(in_ready), 64'd0);
    chk("final_words", 64'(words_loaded), n_ok ? 64'(n) : 64'd0);
  endtask

  task automatic fill_random(input int n);
    fw.delete();
    for (int i = 0; i < n; i++) fw.push_back($urandom);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] sx;

    do_reset();
    fw = '{32'h20080005, 32'hAC080004};
    run_frame(2, 8'h00, 0);

    do_reset();
    run_frame(2, 8'h8D, 0);

    do_reset();
    run_frame(0, 8'h00, 0);
    do_reset();
    run_frame(257, 8'h00, 0);

    do_reset();
    run_frame(2, 8'h00, 1);

    // reset in the middle of a 3-word load, then a fresh 1-word frame
    do_reset();
    fill_random(3);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int k = 0; k < 4; k++) send_byte(8'(fw[0] >> (24 - 8 * k)), 0);
    sb.push_back('{addr: '0, data: fw[0], cnt: 1, cyc: accept_cyc});
    send_byte(8'(fw[1] >> 24), 0);
    @(posedge clk);
    #1;
    chk("abort_pending", 64'(sb.size()), 64'd0);
    chk("abort_words", 64'(words_loaded), 64'd1);
    do_reset();
    fw = '{32'h12345678};
    run_frame(1, 8'h00, 0);

    do_reset();
    fill_random(256);
    run_frame(256, 8'h00, 0);

    for (int it = 0; it < 24; it++) begin
      do_reset();
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = 257 + int'($urandom_range(0, 1000));
        default: n = int'($urandom_range(1, 6));
      endcase
      fill_random((n >= 1 && n <= 256) ? n : 0);
      sx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(n, sx, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_boot_loader.md
Name: mc_boot_loader

Overview:
- Synthesizable program loader that sits directly upstream of the multi-cycle computer's unified instruction/data memory.
- Receives a framed byte stream over a valid/ready handshake, assembles 32-bit words and writes them to consecutive memory word addresses starting at 0.
- Holds the CPU in reset until a complete, checksum-verified image is loaded; only then releases the CPU.
- Replaces simulation-only memory preloading on hardware.

Parameters:
- ADDR_W, 8, memory word-address width; capacity MAX_WORDS = 2**ADDR_W.
- DATA_W, 32, memory word width; fixed at 32, 4 bytes per word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid this cycle.
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid && in_ready at a rising edge.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  word to write.
- cpu_rstn  out  1  active-low reset to the CPU; 0 until load succeeds.
- done  out  1  sticky: image loaded and verified.
- err  out  1  sticky: framing or checksum error.
- words_loaded  out  ADDR_W+1  count of words written so far.

Behaviour:
- Reset (rst=1 at clock edge) values:
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rstn=0, done=0, err=0, words_loaded=0.
  - State goes to LEN_HI; all accumulators and checksum cleared.
  - Reset mid-load aborts the load; no further writes occur.
- Frame format:
  - LEN_HI byte, then LEN_LO byte: N = 16-bit word count, big-endian.
  - 4*N data bytes; each word big-endian (first byte = bits 31:24).
  - One checksum byte = XOR of all 4*N data bytes.
- States: LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR. in_ready=1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in DONE and ERROR.
- LEN_HI: on accept, latch the high byte -> LEN_LO.
- LEN_LO: on accept, form N.
  - N==0 or N>MAX_WORDS -> ERROR.
  - Otherwise -> DATA, with byte index 0 and word index 0.
- DATA:
  - Each accepted byte shifts into the word accumulator and is XORed into the running checksum.
  - On the 4th byte of a word: the next cycle drives mem_we=1 (exactly one cycle), mem_addr=word index, mem_wdata=assembled word. words_loaded increments in that same cycle.
  - Write latency: strobe is high in the cycle immediately after the 4th-byte handshake.
  - in_ready stays 1 during the write cycle, so back-to-back bytes are never stalled.
  - After word N-1's 4th byte -> CHECK.
- CHECK: on accept, compare the byte to the running checksum.
  - Match -> DONE.
  - Mismatch -> ERROR.
  - The final word's mem_we pulse still occurs (it coincides with the CHECK state).
- DONE: done=1 and cpu_rstn=1 from the first cycle in DONE. Terminal until rst.
- ERROR: err=1, cpu_rstn held 0. Terminal until rst.
  - Words already written remain in memory; no rollback.
- No-transfer cycles: in_valid=0 cycles insert wait states; no state or accumulator changes.
- Address arithmetic: mem_addr never wraps; N>MAX_WORDS is rejected up front, so the maximum address is MAX_WORDS-1.
- Mutual exclusion: done and err are never both 1. mem_we is never 1 in DONE except the final-word strobe cycle, and never 1 in ERROR.

Test Plan:
1. rst for 2 cycles, then idle -> all outputs 0, in_ready=1 in the cycle after rst drops, cpu_rstn=0.
2. Stream 00 02 | 20 08 00 05 | AC 08 00 04 | checksum 0x8D (XOR of the 8 data bytes) -> writes addr0=0x20080005 and addr1=0xAC080004, one mem_we pulse each, the cycle after each 4th byte; done=1, cpu_rstn=1, words_loaded=2.
3. Same frame with checksum 0x00 -> both words written; err=1, done=0, cpu_rstn=0, in_ready=0 afterwards.
4. Length 00 00, then length 01 01 (257 > 256) after a reset -> ERROR immediately after LEN_LO, no mem_we ever asserted.
5. Frame of test 2 with in_valid toggled 1/0 every cycle and a 5-cycle gap mid-word -> identical writes and final state to test 2.
6. Assert rst after the first word is written in a 3-word load, then send a full valid 1-word frame 00 01 | 12 34 56 78 | 0x08 -> outputs cleared; addr0=0x12345678 written; done=1, words_loaded=1.
